fp_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one pipelined single-precision FP adder among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the adder. Each in-flight operation is tagged with its requester ID through a shift register matched to the adder latency. Results are returned through a credit-protected result FIFO, because the adder pipeline itself cannot stall.

---
 rtl/fp_add_arb_pkg.sv | 19 +
 rtl/fp_result_fifo.sv | 57 +++++
 rtl/fp_add_arbiter.sv | 129 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_arb_pkg.sv
// Shared types for the FP adder arbiter slice.
// FP_ADD_ARB_STATS_EN in fp_add_arbiter enables grant/stall counters.
package fp_add_arb_pkg;

  typedef logic [31:0] fp32_t;

  localparam int STAT_W   = 16;
  localparam int TAG_ID_W = 3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged adder results.
// Head data reads as zero while empty.
module fp_result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP adder with credit-protected results.
// Define FP_ADD_ARB_STATS_EN to add grant and stall counters.
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDER_LATENCY = 5,
  parameter int FIFO_DEPTH    = 8,
  localparam int IW           = id_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output fp32_t                 add_a,
  output fp32_t                 add_b,
  output logic                  add_in_valid,
  input  fp32_t                 add_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output fp32_t                 rsp_result
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_stalls
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_id;
  logic [CW-1:0] credits;
  logic [CW-1:0] fifo_count;
  logic          issue;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  tag_t          tags [ADDER_LATENCY+1];
  tag_t          tag_out;

  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    gnt_id    = '0;
    issue     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!issue && req_valid[idx] && credits != '0 && !reset) begin
        issue          = 1'b1;
        gnt_id         = IW'(idx);
        req_ready[idx] = 1'b1;
      end
    end
  end

  assign pop     = rsp_valid && rsp_ready;
  // Stage 0 lines up with add_in_valid; the last stage with add_result.
  assign tag_out = tags[ADDER_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      add_a        <= '0;
      add_b        <= '0;
      add_in_valid <= 1'b0;
      rr_ptr       <= '0;
      credits      <= CW'(FIFO_DEPTH);
      for (int s = 0; s <= ADDER_LATENCY; s++) tags[s] <= '0;
    end else begin
      add_in_valid <= issue;
      tags[0]      <= '{valid: issue, id: TAG_ID_W'(gnt_id)};
      for (int s = 1; s <= ADDER_LATENCY; s++) tags[s] <= tags[s-1];
      if (issue) begin
        add_a  <= req_a[int'(gnt_id)*32 +: 32];
        add_b  <= req_b[int'(gnt_id)*32 +: 32];
        rr_ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
      end
      if (issue && !pop)      credits <= credits - 1'b1;
      else if (pop && !issue) credits <= credits + 1'b1;
    end
  end

  fp_result_fifo #(
    .WIDTH (32 + IW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_out.valid),
    .pop   (pop),
    .din   ({tag_out.id[IW-1:0], add_result}),
    .dout  ({rsp_id, rsp_result}),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;

  assert property (@(posedge clk) disable iff (reset)
    !(tag_out.valid && fifo_full));
  assert property (@(posedge clk) disable iff (reset)
    (int'(credits) + int'(fifo_count)) <= FIFO_DEPTH);
  assert property (@(posedge clk) disable iff (reset)
    int'(tag_out.id) < NUM_REQ);

`ifdef FP_ADD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && stat_grants[i*STAT_W +: STAT_W] != '1)
          stat_grants[i*STAT_W +: STAT_W] <=
            stat_grants[i*STAT_W +: STAT_W] + 1'b1;
      end
      if (|req_valid && credits == '0 && stat_stalls != '1)
        stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed tables, corner sequences, random traffic
// against a queue-based reference model and a latency-matched FP adder model.
module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int L  = 5;
  localparam int D  = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic            add_in_valid;
  logic [31:0]     add_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     rsp_result;
`ifdef FP_ADD_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stalls;
`endif

  always #5 clk = ~clk;

  fp_add_arbiter #(
    .NUM_REQ       (N),
    .ADDER_LATENCY (L),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_in_valid (add_in_valid),
    .add_result   (add_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result)
`ifdef FP_ADD_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_stalls  (stat_stalls)
`endif
  );

  // Behavioural single-precision add via double arithmetic (normal inputs).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  logic [31:0] pipe_v  [L];
  logic        pipe_ok [L];

  always @(posedge clk) begin
    pipe_ok[0] <= add_in_valid;
    pipe_v[0]  <= fadd(add_a, add_b);
    for (int k = 1; k < L; k++) begin
      pipe_ok[k] <= pipe_ok[k-1];
      pipe_v[k]  <= pipe_v[k-1];
    end
  end

  assign add_result = pipe_ok[L-1] ? pipe_v[L-1] : 32'hDEADBEEF;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          wr;
  } exp_t;

  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic [N-1:0] want;
  } vec_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rr = 0;
  int          outstanding = 0;
  logic        fix_ops = 1'b0;
  logic [31:0] fix_a = 32'd0;
  logic [31:0] fix_b = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: drive at negedge, check comb outputs, then the edge effects.
  task automatic step(input logic [N-1:0] v, input logic rdy, output logic [N-1:0] seen);
    int          g;
    logic        hv;
    logic [31:0] ea;
    logic [31:0] eb;
    req_valid = v;
    rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = fix_ops ? fix_a : rnd_f();
      req_b[i*32 +: 32] = fix_ops ? fix_b : rnd_f();
    end
    #1;
    g = -1;
    if (outstanding < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
    seen = req_ready;
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    hv = q.size() > 0;
    if (hv) hv = q[0].wr <= cyc;
    chk("rsp_valid", 64'(rsp_valid), 64'(hv));
    if (hv && rdy) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
    end
    ea = 32'd0;
    eb = 32'd0;
    if (g >= 0) begin
      ea = req_a[g*32 +: 32];
      eb = req_b[g*32 +: 32];
    end
    @(posedge clk);
    cyc++;
    if (hv && rdy) begin
      void'(q.pop_front());
      outstanding--;
    end
    if (g >= 0) begin
      q.push_back('{id: g, res: fadd(ea, eb), wr: cyc + 1 + L});
      outstanding++;
      rr = (g + 1) % N;
    end
    #1;
    chk("add_in_valid", 64'(add_in_valid), 64'(g >= 0));
    if (g >= 0) begin
      chk("add_a", 64'(add_a), 64'(ea));
      chk("add_b", 64'(add_b), 64'(eb));
    end
    @(negedge clk);
  endtask

  task automatic stepx(input string nm, input logic [N-1:0] v, input logic rdy,
                       input logic [N-1:0] want);
    logic [N-1:0] s;
    step(v, rdy, s);
    chk(nm, 64'(s), 64'(want));
  endtask

  task automatic idle(input int n, input logic rdy);
    logic [N-1:0] s;
    for (int i = 0; i < n; i++) step('0, rdy, s);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_add_in_valid", 64'(add_in_valid), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
`ifdef FP_ADD_ARB_STATS_EN
    chk("rst_stat_grants", 64'(stat_grants), 64'd0);
    chk("rst_stat_stalls", 64'(stat_stalls), 64'd0);
`endif
    @(negedge clk);
    reset       = 1'b0;
    q.delete();
    outstanding = 0;
    rr          = 0;
  endtask

  vec_t         tbl [14];
  logic [N-1:0] s;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000};
    tbl[12] = '{4'b1100, 1'b1, 4'b0100};
    tbl[13] = '{4'b0110, 1'b0, 4'b0010};

    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    do_reset();

    // Single request with known operands and minimum latency.
    fix_ops = 1'b1;
    fix_a   = 32'h3F800000;
    fix_b   = 32'h40000000;
    stepx("single_gnt", 4'b0001, 1'b0, 4'b0001);
    fix_ops = 1'b0;
    idle(5, 1'b0);
    chk("single_early", 64'(rsp_valid), 64'd0);
    idle(1, 1'b0);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_result", 64'(rsp_result), 64'h40400000);
    idle(2, 1'b1);

    // Round-robin table.
    do_reset();
    for (int i = 0; i < 14; i++)
      stepx($sformatf("tbl%0d", i), tbl[i].v, tbl[i].rdy, tbl[i].want);
    idle(12, 1'b1);

    // Credit exhaustion and same-cycle issue/pop.
    do_reset();
    for (int i = 0; i < 8; i++) stepx("credit_fill", 4'b0100, 1'b0, 4'b0100);
    stepx("credit_empty", 4'b0100, 1'b0, 4'b0000);
    idle(8, 1'b0);
    stepx("zero_credit_pop", 4'b0100, 1'b1, 4'b0000);
    stepx("one_credit_pop", 4'b0100, 1'b1, 4'b0100);
    stepx("credit_kept", 4'b0100, 1'b0, 4'b0100);
    stepx("credit_out", 4'b0100, 1'b0, 4'b0000);
    idle(20, 1'b1);

    // Reset with operations in flight.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, s);
    do_reset();
    idle(10, 1'b1);
    chk("post_reset_empty", 64'(rsp_valid), 64'd0);
    stepx("post_reset_rr", 4'b1111, 1'b0, 4'b0001);
    for (int i = 0; i < 7; i++) stepx("post_reset_credit", 4'b0100, 1'b0, 4'b0100);
    stepx("post_reset_full", 4'b0100, 1'b0, 4'b0000);
    idle(20, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(N'($urandom), $urandom_range(0, 3) != 0, s);
    idle(30, 1'b1);
    chk("drained", 64'(q.size()), 64'd0);

`ifdef FP_ADD_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) stepx("st_g1", 4'b0010, 1'b0, 4'b0010);
    chk("stat_grants_1", 64'(stat_grants[31:16]), 64'd5);
    for (int i = 0; i < 3; i++) stepx("st_g2", 4'b0100, 1'b0, 4'b0100);
    for (int i = 0; i < 3; i++) stepx("st_stall", 4'b0001, 1'b0, 4'b0000);
    chk("stat_stalls", 64'(stat_stalls), 64'd3);
    chk("stat_grants_1b", 64'(stat_grants[31:16]), 64'd5);
    chk("stat_grants_2", 64'(stat_grants[47:32]), 64'd3);
    idle(20, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
